// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one trial subtraction per clock.
//
// Parameters:
//   WIDTH        operand / quotient / remainder width (2..32)
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        division request, honoured in IDLE or DONE
//   dividend     unsigned dividend, captured on an accepted start
//   divisor      unsigned divisor, captured on an accepted start
//   busy         high while iterating (CALC)
//   done         one-cycle strobe, results valid
//   quotient     result quotient, held until the next accepted start
//   remainder    result remainder, held until the next accepted start
//   div_by_zero  divisor was zero (only with zero detection)
//
// Optional feature macro: SEQ_DIVIDER_DIV_ZERO_DETECT_EN
//   defined     : divisor 0 skips CALC, done one cycle after start, div_by_zero=1
//   not defined : divisor 0 runs the normal algorithm, div_by_zero tied to 0
//
// State | meaning
// ------+---------------------------------------------
// IDLE  | ready for a new request
// CALC  | one shift/trial-subtract iteration per cycle
// DONE  | results present, done=1, accepts a new start

module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem_w, quo_w;
  logic [WIDTH-1:0] rem_o, quo_o;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             last_iter;

  // The partial remainder never exceeds 2*divisor-1 after the shift, so a
  // WIDTH+1 bit subtraction is enough and its MSB is a clean borrow flag.
  assign shifted   = {rem_w, quo_w[WIDTH-1]};
  assign trial     = shifted - {1'b0, dvsr};
  assign borrow    = trial[WIDTH];
  assign rem_nxt   = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt   = {quo_w[WIDTH-2:0], ~borrow};
  assign last_iter = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (last_iter) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_CALC;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
    if (accept && (divisor == '0)) state_nxt = S_DONE;
`endif
  end

`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
  logic dbz_q;
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      dvsr  <= '0;
      rem_w <= '0;
      quo_w <= '0;
      rem_o <= '0;
      quo_o <= '0;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
      dbz_q <= 1'b0;
`endif
    end else if (accept) begin
      dvsr  <= divisor;
      quo_w <= dividend;
      rem_w <= '0;
      cnt   <= CW'(WIDTH);
      rem_o <= '0;
      quo_o <= '0;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
      dbz_q <= 1'b0;
      if (divisor == '0) begin
        cnt   <= '0;
        quo_o <= '1;
        rem_o <= dividend;
        dbz_q <= 1'b1;
      end
`endif
    end else if (state == S_CALC) begin
      rem_w <= rem_nxt;
      quo_w <= quo_nxt;
      cnt   <= cnt - CW'(1);
      // Publish on the final iteration so results appear with done.
      if (last_iter) begin
        rem_o <= rem_nxt;
        quo_o <= quo_nxt;
      end
    end
  end

  assign quotient  = quo_o;
  assign remainder = rem_o;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider (WIDTH=8) against
// a cycle-level behavioural model plus literal expectations.
//
// Optional feature macro mirrored from the design: SEQ_DIVIDER_DIV_ZERO_DETECT_EN

module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_chk  = 0;
  int n_fail = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks when the current request finishes (cycle index) and what a
  // correct division produces, using plain / and %.
  int           ecyc = 0;
  bit           pend = 0;
  int           t_done = 0;
  logic [W-1:0] res_q, res_r;
  logic         e_busy = 0, e_done = 0, e_dbz = 0;
  logic [W-1:0] e_q = 0, e_r = 0;

  always @(posedge clk) begin
    ecyc++;
    if (rst) begin
      pend = 0; e_busy = 0; e_done = 0; e_q = 0; e_r = 0; e_dbz = 0;
    end else if (pend) begin
      if (ecyc == t_done) begin
        pend = 0; e_busy = 0; e_done = 1; e_q = res_q; e_r = res_r;
      end else begin
        e_busy = 1; e_done = 0;
      end
    end else begin
      e_done = 0; e_busy = 0;
      if (start) begin
        e_q = 0; e_r = 0; e_dbz = 0;
        if (divisor == 0) begin
          res_q = {W{1'b1}};
          res_r = dividend;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
          e_done = 1; e_q = res_q; e_r = res_r; e_dbz = 1;
`else
          pend = 1; t_done = ecyc + W; e_busy = 1;
`endif
        end else begin
          res_q = dividend / divisor;
          res_r = dividend % divisor;
          pend = 1; t_done = ecyc + W; e_busy = 1;
        end
      end
    end
  end

  // Compare every cycle, just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("quotient", quotient, e_q);
      chk("remainder", remainder, e_r);
      chk("div_by_zero", div_by_zero, e_dbz);
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of cycles from the start cycle to the done cycle;
  // a timeout is reported as a failed comparison.
  task automatic wait_done(input string name, output int n);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, done, 1'b1);
  endtask

  task automatic expect_res(input string name, input int lat, input int exp_lat,
                            input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_q"}, quotient, q);
    chk({name, "_r"}, remainder, r);
    chk({name, "_dbz"}, div_by_zero, z);
  endtask

  initial begin
    int n;
    bit saw_done;
    logic [W-1:0] a, b;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_q", quotient, 0);
    chk("reset_r", remainder, 0);
    chk("reset_dbz", div_by_zero, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    start_op(8'd100, 8'd7);
    chk("100_7_busy", busy, 1'b1);
    wait_done("100_7", n);
    expect_res("100_7", n, 9, 8'd14, 8'd2, 1'b0);

    start_op(8'd255, 8'd1);
    wait_done("255_1", n);
    expect_res("255_1", n, 9, 8'd255, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("255_1_held_q", quotient, 8'd255);
    chk("held_done_low", done, 1'b0);

    start_op(8'd5, 8'd9);
    wait_done("5_9", n);
    expect_res("5_9", n, 9, 8'd0, 8'd5, 1'b0);

    start_op(8'd0, 8'd3);
    wait_done("0_3", n);
    expect_res("0_3", n, 9, 8'd0, 8'd0, 1'b0);

    start_op(8'd200, 8'd0);
    wait_done("200_0", n);
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
    expect_res("200_0", n, 1, 8'd255, 8'd200, 1'b1);
`else
    expect_res("200_0", n, 9, 8'd255, 8'd200, 1'b0);
`endif

    // start during CALC is ignored
    start_op(8'd100, 8'd7);
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", n);
    expect_res("ignore", n, 6, 8'd14, 8'd2, 1'b0);

    // start held through the done cycle launches back-to-back
    start_op(8'd100, 8'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    wait_done("b2b_first", n);
    chk("b2b_first_q", quotient, 8'd14);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_second", n);
    expect_res("b2b_second", n, 9, 8'd10, 8'd0, 1'b0);

    // reset aborts a running division
    start_op(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    chk("abort_no_done", saw_done, 1'b0);

    start_op(8'd9, 8'd2);
    wait_done("9_2", n);
    expect_res("9_2", n, 9, 8'd4, 8'd1, 1'b0);

    // random operand pairs, checked against the division identity
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(1, 255));
      start_op(a, b);
      wait_done("rnd", n);
      chk("rnd_identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      chk("rnd_rem_lt_div", remainder < b, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
